// File: rtl/acc_dp_mem_resp_if.sv
// Dual-port memory initiator bus: port A and port B request/response signals.
// The master drives requests and the slave returns registered read data.
interface acc_dp_mem_resp_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    mem_en_a;
   logic [ADDR_WIDTH-1:0]   mem_addr_a;
   logic                    mem_we_a;
   logic [DATA_WIDTH-1:0]   mem_wdata_a;
   logic [DATA_WIDTH/8-1:0] mem_be_a;
   logic [DATA_WIDTH-1:0]   mem_rdata_a;

   logic                    mem_en_b;
   logic [ADDR_WIDTH-1:0]   mem_addr_b;
   logic                    mem_we_b;
   logic [DATA_WIDTH-1:0]   mem_wdata_b;
   logic [DATA_WIDTH/8-1:0] mem_be_b;
   logic [DATA_WIDTH-1:0]   mem_rdata_b;

   modport master (
      output mem_en_a, mem_addr_a, mem_we_a, mem_wdata_a, mem_be_a,
      output mem_en_b, mem_addr_b, mem_we_b, mem_wdata_b, mem_be_b,
      input  mem_rdata_a, mem_rdata_b
   );

   modport slave (
      input  mem_en_a, mem_addr_a, mem_we_a, mem_wdata_a, mem_be_a,
      input  mem_en_b, mem_addr_b, mem_we_b, mem_wdata_b, mem_be_b,
      output mem_rdata_a, mem_rdata_b
   );
endinterface

// File: rtl/acc_dp_mem_resp.sv
// Dual-port word memory responder: self-zeroing init, byte-enabled writes, held
// registered reads, sticky out-of-range/collision flags and saturating access counters.
module acc_dp_mem_resp #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   acc_dp_mem_resp_if.slave     bus,
   output logic                 ready,
   input  logic                 clr_mem,
   input  logic                 clr_status,
   output logic                 err_oob,
   output logic                 collision,
   output logic [CNT_WIDTH-1:0] rd_cnt,
   output logic [CNT_WIDTH-1:0] wr_cnt
);
   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned BeW  = DATA_WIDTH / 8;
   localparam int unsigned SumW = CNT_WIDTH + 1;

   typedef enum logic [0:0] {StInit, StReady} state_e;

   state_e                state_q;
   logic [IdxW-1:0]       init_cnt_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         ready      <= 1'b0;
      end else begin
         unique case (state_q)
            StInit: begin
               init_cnt_q <= init_cnt_q + 1'b1;
               if (init_cnt_q == IdxW'(DEPTH - 1)) begin
                  state_q <= StReady;
                  ready   <= 1'b1;
               end
            end
            StReady: begin
               if (clr_mem) begin
                  state_q    <= StInit;
                  init_cnt_q <= '0;
                  ready      <= 1'b0;
               end
            end
            default: begin
               state_q    <= StInit;
               init_cnt_q <= '0;
               ready      <= 1'b0;
            end
         endcase
      end
   end

   logic            oob_a, oob_b;
   logic [IdxW-1:0] idx_a, idx_b;
   logic            ld_a, ld_b, rd_a, rd_b, wr_a, wr_b;
   logic            oob_ev, coll_ev;

   always_comb begin
      oob_a   = bus.mem_addr_a[ADDR_WIDTH-1:IdxW] != '0;
      oob_b   = bus.mem_addr_b[ADDR_WIDTH-1:IdxW] != '0;
      idx_a   = bus.mem_addr_a[IdxW-1:0];
      idx_b   = bus.mem_addr_b[IdxW-1:0];
      ld_a    = ready & bus.mem_en_a & ~bus.mem_we_a;
      ld_b    = ready & bus.mem_en_b & ~bus.mem_we_b;
      rd_a    = ld_a & ~oob_a;
      rd_b    = ld_b & ~oob_b;
      wr_a    = ready & bus.mem_en_a & bus.mem_we_a & ~oob_a;
      wr_b    = ready & bus.mem_en_b & bus.mem_we_b & ~oob_b;
      oob_ev  = ready & ((bus.mem_en_a & oob_a) | (bus.mem_en_b & oob_b));
      coll_ev = ready & bus.mem_en_a & bus.mem_en_b & ~oob_a & ~oob_b & (idx_a == idx_b) &
                (bus.mem_we_a | bus.mem_we_b);
   end

   // Port B bytes are written first so port A wins any byte both ports enable.
   always_ff @(posedge clk) begin
      if (state_q == StInit) begin
         mem[init_cnt_q] <= '0;
      end else begin
         for (int i = 0; i < BeW; i++) begin
            if (wr_b && bus.mem_be_b[i]) mem[idx_b][8*i +: 8] <= bus.mem_wdata_b[8*i +: 8];
            if (wr_a && bus.mem_be_a[i]) mem[idx_a][8*i +: 8] <= bus.mem_wdata_a[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         if (ld_a) rdata_a_q <= oob_a ? '0 : mem[idx_a];
         if (ld_b) rdata_b_q <= oob_b ? '0 : mem[idx_b];
      end
   end

   assign bus.mem_rdata_a = rdata_a_q;
   assign bus.mem_rdata_b = rdata_b_q;

   logic [SumW-1:0]      rd_sum, wr_sum;
   logic [CNT_WIDTH-1:0] rd_cnt_d, wr_cnt_d;

   always_comb begin
      rd_sum   = {1'b0, rd_cnt} + SumW'({1'b0, rd_a} + {1'b0, rd_b});
      wr_sum   = {1'b0, wr_cnt} + SumW'({1'b0, wr_a} + {1'b0, wr_b});
      rd_cnt_d = rd_sum[CNT_WIDTH] ? '1 : rd_sum[CNT_WIDTH-1:0];
      wr_cnt_d = wr_sum[CNT_WIDTH] ? '1 : wr_sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_oob   <= 1'b0;
         collision <= 1'b0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
      end else if (clr_status) begin
         err_oob   <= 1'b0;
         collision <= 1'b0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
      end else begin
         err_oob   <= err_oob | oob_ev;
         collision <= collision | coll_ev;
         rd_cnt    <= rd_cnt_d;
         wr_cnt    <= wr_cnt_d;
      end
   end
endmodule

// File: tb/tb_acc_dp_mem_resp.sv
// Directed plus randomized bench for acc_dp_mem_resp against a word-array reference model.
module tb_acc_dp_mem_resp;
   localparam int AW = 32, DW = 32, DEPTH = 256, CW = 16, BW = DW / 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0, rst_n = 1'b0, clr_mem = 1'b0, clr_status = 1'b0;
   logic          ready, err_oob, collision;
   logic [CW-1:0] rd_cnt, wr_cnt;

   acc_dp_mem_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   acc_dp_mem_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ready     (ready),
      .clr_mem   (clr_mem),
      .clr_status(clr_status),
      .err_oob   (err_oob),
      .collision (collision),
      .rd_cnt    (rd_cnt),
      .wr_cnt    (wr_cnt)
   );

   always #5 clk = ~clk;

   int n_total = 0, n_pass = 0, n_fail = 0;

   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_rd_a, m_rd_b;
   bit            m_ready, m_oob, m_col;
   int            m_init_left, m_rd, m_wr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ready"}, 64'(ready), 64'(m_ready));
      check({tag, ".rdata_a"}, 64'(bus.mem_rdata_a), 64'(m_rd_a));
      check({tag, ".rdata_b"}, 64'(bus.mem_rdata_b), 64'(m_rd_b));
      check({tag, ".err_oob"}, 64'(err_oob), 64'(m_oob));
      check({tag, ".collision"}, 64'(collision), 64'(m_col));
      check({tag, ".rd_cnt"}, 64'(rd_cnt), 64'(m_rd));
      check({tag, ".wr_cnt"}, 64'(wr_cnt), 64'(m_wr));
   endtask

   task automatic model_reset();
      foreach (m_mem[i]) m_mem[i] = '0;
      m_rd_a = '0; m_rd_b = '0; m_ready = 0; m_init_left = DEPTH;
      m_oob = 0; m_col = 0; m_rd = 0; m_wr = 0;
   endtask

   // Drive one cycle of requests, advance the model by the same rules, then compare.
   task automatic step(input string tag,
                       input bit ea, input bit wa, input logic [AW-1:0] aa,
                       input logic [DW-1:0] da, input logic [BW-1:0] ba,
                       input bit eb, input bit wb, input logic [AW-1:0] ab,
                       input logic [DW-1:0] db, input logic [BW-1:0] bb);
      bit ain, bin;
      bus.mem_en_a = ea; bus.mem_we_a = wa; bus.mem_addr_a = aa;
      bus.mem_wdata_a = da; bus.mem_be_a = ba;
      bus.mem_en_b = eb; bus.mem_we_b = wb; bus.mem_addr_b = ab;
      bus.mem_wdata_b = db; bus.mem_be_b = bb;
      ain = aa < DEPTH;
      bin = ab < DEPTH;
      if (m_ready) begin
         if (ea && !wa) m_rd_a = ain ? m_mem[int'(aa)] : '0;
         if (eb && !wb) m_rd_b = bin ? m_mem[int'(ab)] : '0;
         for (int i = 0; i < BW; i++) begin
            if (eb && wb && bin && bb[i]) m_mem[int'(ab)][8*i +: 8] = db[8*i +: 8];
            if (ea && wa && ain && ba[i]) m_mem[int'(aa)][8*i +: 8] = da[8*i +: 8];
         end
         m_oob = m_oob || (ea && !ain) || (eb && !bin);
         m_col = m_col || (ea && eb && ain && bin && aa == ab && (wa || wb));
         m_rd  = m_rd + int'(ea && !wa && ain) + int'(eb && !wb && bin);
         m_wr  = m_wr + int'(ea && wa && ain) + int'(eb && wb && bin);
         if (m_rd > CMAX) m_rd = CMAX;
         if (m_wr > CMAX) m_wr = CMAX;
         if (clr_mem) begin
            m_ready = 0;
            m_init_left = DEPTH;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end else begin
         m_init_left--;
         if (m_init_left == 0) m_ready = 1;
      end
      if (clr_status) begin
         m_oob = 0; m_col = 0; m_rd = 0; m_wr = 0;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
   endtask

   int saved_rd, saved_wr;

   initial begin
      idle_drive: begin
         bus.mem_en_a = 0; bus.mem_we_a = 0; bus.mem_addr_a = '0;
         bus.mem_wdata_a = '0; bus.mem_be_a = '0;
         bus.mem_en_b = 0; bus.mem_we_b = 0; bus.mem_addr_b = '0;
         bus.mem_wdata_b = '0; bus.mem_be_b = '0;
      end
      model_reset();
      #2;
      check_all("reset");
      #10 rst_n = 1'b1;

      // Init after reset: ready low for DEPTH cycles, then high.
      for (int i = 0; i < DEPTH - 1; i++) idle("init");
      check("init_still_low", 64'(ready), 64'd0);
      idle("init_last");
      check("ready_rises", 64'(ready), 64'd1);
      step("rd0", 1, 0, 32'd0, '0, '0, 1, 0, 32'd255, '0, '0);
      check("rd0_a_zero", 64'(bus.mem_rdata_a), 64'd0);
      check("rd0_cnt", 64'(rd_cnt), 64'd2);

      // Byte-enabled writes from both ports, held read data.
      clr_status = 1; idle("clr1"); clr_status = 0;
      step("w3a", 1, 1, 32'd3, 32'h11223344, 4'hF, 0, 0, '0, '0, '0);
      step("w3b", 0, 0, '0, '0, '0, 1, 1, 32'd3, 32'hAABBCCDD, 4'b0101);
      step("r3a", 1, 0, 32'd3, '0, '0, 0, 0, '0, '0, '0);
      check("t2_rdata", 64'(bus.mem_rdata_a), 64'h11BB33DD);
      check("t2_wr_cnt", 64'(wr_cnt), 64'd2);
      check("t2_rd_cnt", 64'(rd_cnt), 64'd1);
      step("w5a", 1, 1, 32'd5, 32'hCAFEF00D, 4'hF, 0, 0, '0, '0, '0);
      check("t2_hold", 64'(bus.mem_rdata_a), 64'h11BB33DD);

      // Same-address double write: A wins on its enabled bytes.
      step("ww7", 1, 1, 32'd7, 32'hFFFFFFFF, 4'b0011, 1, 1, 32'd7, 32'h12345678, 4'hF);
      check("t3_coll", 64'(collision), 64'd1);
      step("r7b", 0, 0, '0, '0, '0, 1, 0, 32'd7, '0, '0);
      check("t3_mem7", 64'(bus.mem_rdata_b), 64'h1234FFFF);
      clr_status = 1; idle("clr2"); clr_status = 0;
      check("t3_coll_clr", 64'(collision), 64'd0);
      check("t3_cnt_clr", 64'(rd_cnt) + 64'(wr_cnt), 64'd0);

      // Read-first on read/write conflict.
      step("w9", 1, 1, 32'd9, 32'h5, 4'hF, 0, 0, '0, '0, '0);
      step("rw9", 1, 0, 32'd9, '0, '0, 1, 1, 32'd9, 32'h6, 4'hF);
      check("t4_old", 64'(bus.mem_rdata_a), 64'h5);
      check("t4_coll", 64'(collision), 64'd1);
      step("r9", 1, 0, 32'd9, '0, '0, 0, 0, '0, '0, '0);
      check("t4_new", 64'(bus.mem_rdata_a), 64'h6);

      // Out-of-range accesses.
      saved_rd = m_rd; saved_wr = m_wr;
      step("oob_r", 1, 0, 32'd256, '0, '0, 0, 0, '0, '0, '0);
      check("t5_rdata", 64'(bus.mem_rdata_a), 64'd0);
      check("t5_oob", 64'(err_oob), 64'd1);
      check("t5_rd_cnt", 64'(rd_cnt), 64'(saved_rd));
      step("oob_w", 1, 1, 32'h1000_0000, 32'hDEADBEEF, 4'hF, 0, 0, '0, '0, '0);
      check("t5_wr_cnt", 64'(wr_cnt), 64'(saved_wr));
      step("r0", 1, 0, 32'd0, '0, '0, 0, 0, '0, '0, '0);
      check("t5_no_alias", 64'(bus.mem_rdata_a), 64'd0);

      // Randomized traffic over a small address window with occasional out-of-range.
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] ra, rb;
         ra = ($urandom_range(0, 15) == 0) ? $urandom() | 32'h100 : AW'($urandom_range(0, 15));
         rb = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(240, 300))
                                          : AW'($urandom_range(0, 15));
         clr_status = ($urandom_range(0, 40) == 0);
         step("rand", 1'($urandom), 1'($urandom), ra, $urandom(), 4'($urandom),
              1'($urandom), 1'($urandom), rb, $urandom(), 4'($urandom));
      end
      clr_status = 0;

      // clr_mem re-zeroes memory; a clr_mem during INIT is ignored.
      step("w10", 1, 1, 32'd10, 32'hDEADBEEF, 4'hF, 0, 0, '0, '0, '0);
      clr_mem = 1; idle("clrmem"); clr_mem = 0;
      check("t6_ready_drop", 64'(ready), 64'd0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         clr_mem = (i == 50);
         idle("reinit");
      end
      clr_mem = 0;
      check("t6_still_low", 64'(ready), 64'd0);
      idle("reinit_last");
      check("t6_ready", 64'(ready), 64'd1);
      for (int i = 0; i < DEPTH / 2; i++)
         step("scan", 1, 0, AW'(i), '0, '0, 1, 0, AW'(i + DEPTH / 2), '0, '0);
      step("r10", 1, 0, 32'd10, '0, '0, 0, 0, '0, '0, '0);
      check("t6_zeroed", 64'(bus.mem_rdata_a), 64'd0);

      // Reset in the middle of INIT restarts from word 0.
      clr_mem = 1; idle("clrmem2"); clr_mem = 0;
      for (int i = 0; i < 100; i++) idle("mid");
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      #3 rst_n = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) idle("init2");
      check("t6_rst_low", 64'(ready), 64'd0);
      idle("init2_last");
      check("t6_rst_ready", 64'(ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/acc_dp_mem_resp.md
Name: acc_dp_mem_resp

Overview:
- Dual-port word-addressed memory responder that serves the accelerator's two memory initiator ports (A and B).
- Each port presents en/addr/we/wdata/be and receives rdata.
- Provides 1-cycle registered read latency with data held until the next read, byte-enabled writes, and a self-clearing init sequence.
- Sticky error/collision status and access counters feed the accelerator status registers.

Parameters:
- ADDR_WIDTH, 32, width of port address buses (word address).
- DATA_WIDTH, 32, data width; multiple of 8.
- DEPTH, 256, number of words; power of two, ≥ 2.
- CNT_WIDTH, 16, width of access counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ready  out  1  memory initialised and accepting accesses
- clr_mem  in  1  pulse: re-zero memory (re-enter INIT)
- clr_status  in  1  pulse: clear sticky flags and counters
- mem_en_a / mem_en_b  in  1  access request, port A / B
- mem_addr_a / mem_addr_b  in  ADDR_WIDTH  word address
- mem_we_a / mem_we_b  in  1  1 = write, 0 = read
- mem_wdata_a / mem_wdata_b  in  DATA_WIDTH  write data
- mem_be_a / mem_be_b  in  DATA_WIDTH/8  byte enables
- mem_rdata_a / mem_rdata_b  out  DATA_WIDTH  registered read data
- err_oob  out  1  sticky: access with addr ≥ DEPTH
- collision  out  1  sticky: same-address conflict involving a write
- rd_cnt  out  CNT_WIDTH  accepted reads, both ports, saturating
- wr_cnt  out  CNT_WIDTH  accepted writes, both ports, saturating

Behaviour:
- Reset values:
  - State is INIT, init counter 0, ready=0.
  - rdata_a = rdata_b = 0.
  - err_oob=0, collision=0, rd_cnt=0, wr_cnt=0.
  - Memory contents are not reset directly; INIT clears them.
- State machine:
  - INIT: writes 0 to word init_cnt each cycle. init_cnt increments. At init_cnt == DEPTH-1, go to READY next cycle. INIT takes exactly DEPTH cycles.
  - READY: ready=1. clr_mem=1 → INIT with init_cnt=0; ready drops the next cycle. clr_mem is ignored while in INIT.
  - Reset mid-INIT or mid-READY restarts INIT from word 0.
- Port accesses are accepted only when ready=1. When ready=0, en is ignored: no write, rdata held, counters unchanged.
- Read (en=1, we=0, addr < DEPTH): rdata_x <= mem[addr] at the next clk edge. rdata_x holds that value until the next accepted read on the same port. Writes do not disturb it, which lets the initiator consume rdata during its following write cycle.
- Write (en=1, we=1, addr < DEPTH): for each i with be[i]=1, byte i of mem[addr] <= byte i of wdata. Bytes with be[i]=0 are unchanged. rdata_x is unchanged.
- Out-of-range (addr ≥ DEPTH; all upper address bits are compared):
  - No memory update.
  - A read loads rdata_x=0.
  - err_oob is set.
  - Not counted in rd_cnt or wr_cnt.
- Same cycle, same in-range address, both ports enabled:
  - Both write: per byte, port A's byte wins where be_a[i]=1; otherwise port B's byte applies. collision is set.
  - One reads, the other writes: read-first, so the reader gets the old contents. collision is set.
  - Both read: both get the data; no collision.
- Counters: each accepted in-range access adds 1 to its counter; two simultaneous accesses of the same kind add 2. Counters saturate at all-ones.
- clr_status=1: flags and counters cleared at the next edge. Events in that same cycle are dropped; clear has priority.
- Width rules:
  - Internal index is addr[$clog2(DEPTH)-1:0], used only when the out-of-range check passes.
  - Counter addition uses CNT_WIDTH+1 bits before saturation.

Test Plan:
1. Reset, hold all en=0 → ready=0 for 256 cycles and =1 in cycle 257. A read of any addr 0..255 on either port returns 0x00000000. rd_cnt increments per read.
2. Write A addr 3 = 0x11223344 be=4'hF; write B addr 3 wdata 0xAABBCCDD be=4'b0101; then read A addr 3 → rdata_a=0x11BB33DD one cycle after en. rdata_a stays unchanged during the following write cycle. wr_cnt=2, rd_cnt=1.
3. Same cycle: A writes addr 7=0xFFFFFFFF be=4'b0011, B writes addr 7=0x12345678 be=4'hF → mem[7]=0x1234FFFF, collision=1. Assert clr_status → collision=0, counters=0.
4. Same cycle: A reads addr 9 (holding 0x5), B writes addr 9=0x6 → rdata_a=0x5 and a later read returns 0x6. collision=1.
5. A read at addr 256 → rdata_a=0, err_oob=1, memory unchanged, rd_cnt unchanged. A write at addr 0x1000_0000 → no write, err_oob stays 1.
6. Pulse clr_mem after writing data → ready=0 for 256 cycles, then all words read 0. Assert rst_n=0 at init_cnt=100 → INIT restarts and ready rises exactly 256 cycles after rst_n deasserts.
